// File: rtl/password_pkg.sv
// Shared definitions for the keypad password lock controller: FSM state codes
// and the LED pair encodings driven to the lock datapath.
package password_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_PASS  = 3'd3;
  localparam logic [2:0] S_FAIL  = 3'd4;
  localparam logic [2:0] S_LOCK  = 3'd5;
  localparam logic [2:0] S_PROG  = 3'd6;

  localparam logic [1:0] LED_OFF  = 2'b00;
  localparam logic [1:0] LED_PASS = 2'b01;
  localparam logic [1:0] LED_FAIL = 2'b10;

  function automatic logic [1:0] state_led(input logic [2:0] st);
    logic [1:0] led;
    led = LED_OFF;
    if (st == S_PASS) led = LED_PASS;
    else if (st == S_FAIL || st == S_LOCK) led = LED_FAIL;
    return led;
  endfunction

endpackage

// File: rtl/password_ctrl_key_debounce.sv
// Keypad conditioner: 2-flop synchroniser, stability counter, one event per
// press, and a release requirement before the next press is accepted.
module key_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [9:0] button,
  output logic       key_evt,
  output logic [3:0] digit
);

  localparam int CNTW = $clog2(DEB_CYCLES + 1);

  logic [9:0]      sync1;
  logic [9:0]      sync2;
  logic [CNTW-1:0] stable_cnt;
  logic            wait_release;
  logic            one_hot;
  logic            settled;

  function automatic logic [3:0] to_index(input logic [9:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int k = 0; k < 10; k++)
      if (v[k]) idx = 4'(k);
    return idx;
  endfunction

  assign one_hot = (sync2 != 10'd0) && ((sync2 & (sync2 - 10'd1)) == 10'd0);
  assign settled = (stable_cnt == CNTW'(DEB_CYCLES));

  // stable_cnt is the run length of the current synced value, capped at DEB_CYCLES
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1        <= '0;
      sync2        <= '0;
      stable_cnt   <= '0;
      wait_release <= 1'b0;
      key_evt      <= 1'b0;
      digit        <= '0;
    end else begin
      sync1   <= button;
      sync2   <= sync1;
      key_evt <= 1'b0;
      if (sync1 != sync2) stable_cnt <= CNTW'(1);
      else if (!settled)  stable_cnt <= stable_cnt + CNTW'(1);
      if (settled && !wait_release && one_hot) begin
        key_evt      <= 1'b1;
        digit        <= to_index(sync2);
        wait_release <= 1'b1;
      end else if (settled && wait_release && sync2 == 10'd0) begin
        wait_release <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/password_ctrl.sv
// Keypad password lock sequencer: code entry and compare, failure counting with
// lockout, reprogramming of the stored code, and the pass/fail LED pair.
module password_ctrl
  import password_pkg::*;
#(
  parameter int                    CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h1234,
  parameter int                    DEB_CYCLES     = 16,
  parameter int                    TIMEOUT_CYCLES = 2000,
  parameter int                    RESULT_CYCLES  = 100,
  parameter int                    LOCK_CYCLES    = 1000,
  parameter int                    MAX_FAIL       = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [9:0] button,
  input  logic       set_mode,
  output logic [1:0] led_out,
  output logic       locked,
  output logic       busy,
  output logic [2:0] digit_cnt
);

  localparam int CW    = 4 * CODE_LEN;
  localparam int MAXT0 = (TIMEOUT_CYCLES > RESULT_CYCLES) ? TIMEOUT_CYCLES : RESULT_CYCLES;
  localparam int MAXT  = (MAXT0 > LOCK_CYCLES) ? MAXT0 : LOCK_CYCLES;
  localparam int TW    = $clog2(MAXT) + 1;
  localparam int FW    = $clog2(MAX_FAIL + 1);

  // Timer holds remaining cycles minus one; a state ends on the cycle it reads zero
  localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_RESULT  = TW'(RESULT_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK    = TW'(LOCK_CYCLES - 1);
  localparam logic [FW-1:0] F_MAX     = FW'(MAX_FAIL);

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [3:0]    cnt;
  logic          mismatch;
  logic [FW-1:0] fail_cnt;
  logic [CW-1:0] code;
  logic [CW-1:0] shadow;
  logic          key_evt;
  logic [3:0]    key_digit;
  logic          last_digit;
  logic          expired;

  // Digit position 0 is the most-significant nibble (entered first)
  function automatic logic [3:0] code_digit(input logic [CW-1:0] c, input logic [3:0] pos);
    int idx;
    idx = 4 * (CODE_LEN - 1 - int'(pos));
    return c[idx +: 4];
  endfunction

  function automatic logic [CW-1:0] put_digit(input logic [CW-1:0] c, input logic [3:0] pos,
                                              input logic [3:0] d);
    logic [CW-1:0] r;
    int idx;
    r   = c;
    idx = 4 * (CODE_LEN - 1 - int'(pos));
    r[idx +: 4] = d;
    return r;
  endfunction

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
    .clk     (clk),
    .n_rst   (n_rst),
    .button  (button),
    .key_evt (key_evt),
    .digit   (key_digit)
  );

  assign last_digit = (int'(cnt) == CODE_LEN - 1);
  assign expired    = (timer == '0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      cnt      <= '0;
      mismatch <= 1'b0;
      fail_cnt <= '0;
      code     <= DEFAULT_CODE;
      shadow   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_ENTRY;
            cnt      <= '0;
            mismatch <= 1'b0;
            timer    <= T_TIMEOUT;
          end
        end
        S_ENTRY: begin
          if (key_evt) begin
            mismatch <= mismatch | (key_digit != code_digit(code, cnt));
            cnt      <= cnt + 4'd1;
            timer    <= T_TIMEOUT;
            if (last_digit) state <= S_CHECK;
          end else if (expired) begin
            state <= S_FAIL;
            timer <= T_RESULT;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_CHECK: begin
          timer <= T_RESULT;
          if (mismatch) begin
            state    <= S_FAIL;
            fail_cnt <= (fail_cnt == F_MAX) ? fail_cnt : fail_cnt + FW'(1);
          end else begin
            state    <= S_PASS;
            fail_cnt <= '0;
          end
        end
        S_PASS: begin
          if (expired) begin
            if (set_mode) begin
              state <= S_PROG;
              cnt   <= '0;
              timer <= T_TIMEOUT;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_FAIL: begin
          if (expired) begin
            if (fail_cnt == F_MAX) begin
              state <= S_LOCK;
              timer <= T_LOCK;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_LOCK: begin
          if (expired) begin
            state    <= S_IDLE;
            fail_cnt <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_PROG: begin
          if (key_evt) begin
            shadow <= put_digit(shadow, cnt, key_digit);
            cnt    <= cnt + 4'd1;
            timer  <= T_TIMEOUT;
            if (last_digit) begin
              code  <= put_digit(shadow, cnt, key_digit);
              state <= S_IDLE;
            end
          end else if (expired) begin
            state <= S_IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign led_out   = state_led(state);
  assign locked    = (state == S_LOCK);
  assign busy      = (state != S_IDLE);
  assign digit_cnt = cnt[2:0];

endmodule

// File: tb/tb_password_ctrl.sv
// Self-checking bench for password_ctrl: vector table, directed corner sequences
// and randomized keypad traffic against a behavioural model.
module tb_password_ctrl;

  localparam int CODE_LEN = 4;
  localparam int DEB      = 2;
  localparam int TO       = 20;
  localparam int RES      = 4;
  localparam int LCK      = 8;
  localparam int MAXF     = 3;

  localparam int P_IDLE = 0, P_ENTRY = 1, P_CHECK = 2, P_PASS = 3,
                 P_FAIL = 4, P_LOCK = 5, P_PROG = 6;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic [9:0] button;
  logic       set_mode;
  logic [1:0] led_out;
  logic       locked;
  logic       busy;
  logic [2:0] digit_cnt;
  logic [6:0] outs;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int         m_phase;
  int         m_elapsed;
  int         m_idle;
  int         m_fails;
  int         m_code[CODE_LEN];
  int         m_digits[$];
  logic [9:0] hist[$];
  bit         m_wait;
  bit         m_evt;
  int         m_evt_digit;

  typedef struct {
    bit         start;
    bit         set_mode;
    logic [9:0] button;
    int         cycles;
    logic [6:0] exp;
  } step_t;
  step_t steps[$];

  always #5 clk = ~clk;

  password_ctrl #(
    .CODE_LEN(CODE_LEN), .DEFAULT_CODE(16'h1234), .DEB_CYCLES(DEB),
    .TIMEOUT_CYCLES(TO), .RESULT_CYCLES(RES), .LOCK_CYCLES(LCK), .MAX_FAIL(MAXF)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .button(button), .set_mode(set_mode),
    .led_out(led_out), .locked(locked), .busy(busy), .digit_cnt(digit_cnt)
  );

  assign outs = {led_out, locked, busy, digit_cnt};

  function automatic logic [6:0] pk(input logic [1:0] l, input bit lk, input bit bz, input int dc);
    return {l, lk, bz, 3'(dc)};
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b (led,locked,busy,cnt)", name, $time, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase   = P_IDLE;
    m_elapsed = 0;
    m_idle    = 0;
    m_fails   = 0;
    m_code    = '{1, 2, 3, 4};
    m_digits.delete();
    hist.delete();
    for (int i = 0; i < DEB + 2; i++) hist.push_back('0);
    m_wait      = 0;
    m_evt       = 0;
    m_evt_digit = 0;
  endfunction

  function automatic logic [6:0] model_out();
    logic [1:0] l;
    l = (m_phase == P_PASS) ? 2'b01 : (m_phase == P_FAIL || m_phase == P_LOCK) ? 2'b10 : 2'b00;
    return pk(l, m_phase == P_LOCK, m_phase != P_IDLE, m_digits.size());
  endfunction

  // One clock edge: the sequencer reacts to the event visible before the edge,
  // then the keypad history decides whether an event is visible after it.
  function automatic void model_step(input bit st, input bit sm, input logic [9:0] raw);
    bit         ok;
    int         sz;
    bit         settled;
    logic [9:0] v;
    case (m_phase)
      P_IDLE: if (st) begin m_phase = P_ENTRY; m_digits.delete(); m_idle = 0; end
      P_ENTRY: begin
        if (m_evt) begin
          m_digits.push_back(m_evt_digit);
          m_idle = 0;
          if (m_digits.size() == CODE_LEN) m_phase = P_CHECK;
        end else begin
          m_idle++;
          if (m_idle == TO) begin m_phase = P_FAIL; m_elapsed = 0; end
        end
      end
      P_CHECK: begin
        ok = 1;
        for (int i = 0; i < CODE_LEN; i++) if (m_digits[i] != m_code[i]) ok = 0;
        m_elapsed = 0;
        if (ok) begin m_phase = P_PASS; m_fails = 0; end
        else begin m_phase = P_FAIL; m_fails = (m_fails < MAXF) ? m_fails + 1 : MAXF; end
      end
      P_PASS: begin
        m_elapsed++;
        if (m_elapsed == RES) begin
          if (sm) begin m_phase = P_PROG; m_digits.delete(); m_idle = 0; end
          else m_phase = P_IDLE;
        end
      end
      P_FAIL: begin
        m_elapsed++;
        if (m_elapsed == RES) begin
          m_phase = (m_fails == MAXF) ? P_LOCK : P_IDLE;
          m_elapsed = 0;
        end
      end
      P_LOCK: begin
        m_elapsed++;
        if (m_elapsed == LCK) begin m_phase = P_IDLE; m_fails = 0; end
      end
      default: begin
        if (m_evt) begin
          m_digits.push_back(m_evt_digit);
          m_idle = 0;
          if (m_digits.size() == CODE_LEN) begin
            for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_digits[i];
            m_phase = P_IDLE;
          end
        end else begin
          m_idle++;
          if (m_idle == TO) m_phase = P_IDLE;
        end
      end
    endcase
    // The synced value lags raw by two edges and must hold DEB consecutive samples
    sz = hist.size();
    v = hist[sz-2];
    settled = 1;
    for (int j = 2; j <= DEB + 1; j++) if (hist[sz-j] != v) settled = 0;
    m_evt = 0;
    if (settled && !m_wait && $onehot(v)) begin
      m_evt  = 1;
      m_wait = 1;
      for (int k = 0; k < 10; k++) if (v[k]) m_evt_digit = k;
    end else if (settled && m_wait && v == 10'd0) begin
      m_wait = 0;
    end
    hist.push_back(raw);
    void'(hist.pop_front());
  endfunction

  task automatic tick();
    @(posedge clk);
    if (n_rst) model_step(start, set_mode, button);
    #1;
    check("cycle", outs, model_out());
  endtask

  task automatic press(input int d, input int hold, input int rel);
    button = 10'(1 << d);
    repeat (hold) tick();
    button = '0;
    repeat (rel) tick();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic entry(input int a, input int b, input int c, input int e);
    start_pulse();
    press(a, 5, 5);
    press(b, 5, 5);
    press(c, 5, 5);
    press(e, 5, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int codes[3][4];
    bit good[3];
    int lock_cnt;
    int r;
    int d;
    logic [1:0] res;

    codes = '{'{1, 2, 3, 4}, '{1, 2, 9, 4}, '{1, 2, 3, 4}};
    good  = '{1, 0, 1};
    for (int e = 0; e < 3; e++) begin
      res = good[e] ? 2'b01 : 2'b10;
      steps.push_back('{1, 0, 10'd0, 1, pk(2'b00, 0, 1, 0)});
      for (int i = 0; i < 4; i++) begin
        steps.push_back('{0, 0, 10'(1 << codes[e][i]), 5, pk(2'b00, 0, 1, i + 1)});
        if (i < 3) steps.push_back('{0, 0, 10'd0, 5, pk(2'b00, 0, 1, i + 1)});
      end
      steps.push_back('{0, 0, 10'd0, 1, pk(res, 0, 1, 4)});
      steps.push_back('{0, 0, 10'd0, 3, pk(res, 0, 1, 4)});
      steps.push_back('{0, 0, 10'd0, 1, pk(2'b00, 0, 0, 4)});
    end

    n_rst = 1'b0; start = 1'b0; set_mode = 1'b0; button = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", outs, 7'd0);
    n_rst = 1'b1;

    foreach (steps[i]) begin
      start    = steps[i].start;
      set_mode = steps[i].set_mode;
      button   = steps[i].button;
      repeat (steps[i].cycles) tick();
      check($sformatf("vec%0d", i), outs, steps[i].exp);
    end
    start = 1'b0; button = '0;

    // Lockout after three wrong entries; start pulses inside LOCK are ignored
    for (int n = 0; n < 2; n++) begin
      entry(1, 2, 9, 4);
      repeat (5) tick();
    end
    entry(1, 2, 9, 4);
    lock_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i >= 6 && i <= 10);
      tick();
      if (locked) lock_cnt++;
    end
    start = 1'b0;
    check_int("lock_cycles", lock_cnt, LCK);
    check("lock_exit", outs, pk(2'b00, 0, 0, 4));
    entry(1, 2, 3, 4);
    tick();
    check("pass_after_lock", outs, pk(2'b01, 0, 1, 4));
    repeat (4) tick();

    // Entry timeout
    start_pulse();
    press(1, 5, 5);
    repeat (14) tick();
    check("timeout_wait", outs, pk(2'b00, 0, 1, 1));
    tick();
    check("timeout_fail", outs, pk(2'b10, 0, 1, 1));
    repeat (4) tick();
    check("timeout_idle", outs, pk(2'b00, 0, 0, 1));
    start_pulse();
    check("cnt_cleared", outs, pk(2'b00, 0, 1, 0));
    repeat (24) tick();
    check("timeout_idle2", outs, pk(2'b00, 0, 0, 0));

    // Glitch and multi-hot produce no digit
    start_pulse();
    button = 10'(1 << 5);
    tick();
    button = '0;
    repeat (6) tick();
    check("glitch", outs, pk(2'b00, 0, 1, 0));
    button = 10'b00_0001_1000;
    repeat (10) tick();
    button = '0;
    repeat (2) tick();
    check("multihot", outs, pk(2'b00, 0, 1, 0));
    tick();
    check("glitch_timeout", outs, pk(2'b10, 0, 1, 0));
    repeat (4) tick();

    // A long hold yields a single digit
    start_pulse();
    button = 10'(1 << 7);
    repeat (18) tick();
    check("hold_one_evt", outs, pk(2'b00, 0, 1, 1));
    repeat (12) tick();
    button = '0;
    repeat (6) tick();
    check("hold_end", outs, pk(2'b00, 0, 0, 1));

    // Reprogram to 5678
    entry(1, 2, 3, 4);
    set_mode = 1'b1;
    repeat (5) tick();
    set_mode = 1'b0;
    check("prog_enter", outs, pk(2'b00, 0, 1, 0));
    press(5, 5, 5);
    press(6, 5, 5);
    press(7, 5, 5);
    press(8, 5, 0);
    check("prog_done", outs, pk(2'b00, 0, 0, 4));
    repeat (5) tick();
    entry(5, 6, 7, 8);
    tick();
    check("new_code", outs, pk(2'b01, 0, 1, 4));
    repeat (4) tick();
    entry(1, 2, 3, 4);
    tick();
    check("old_code", outs, pk(2'b10, 0, 1, 4));
    repeat (4) tick();

    // Asynchronous reset mid-entry restores the default code
    start_pulse();
    press(1, 5, 5);
    press(2, 5, 5);
    check("pre_reset", outs, pk(2'b00, 0, 1, 2));
    n_rst = 1'b0;
    #2;
    check("async_reset", outs, 7'd0);
    model_reset();
    repeat (2) tick();
    n_rst = 1'b1;
    entry(1, 2, 3, 4);
    tick();
    check("default_after_reset", outs, pk(2'b01, 0, 1, 4));
    repeat (4) tick();

    // Randomized traffic against the model
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      set_mode = 1'($urandom_range(0, 1));
      if (r < 2) begin
        start_pulse();
      end else if (r == 2) begin
        button = 10'($urandom);
        repeat ($urandom_range(1, 4)) tick();
        button = '0;
        repeat (3) tick();
      end else if (r == 9) begin
        repeat ($urandom_range(1, 25)) tick();
      end else begin
        d = ($urandom_range(0, 3) != 0) ? m_code[m_digits.size() % CODE_LEN]
                                        : int'($urandom_range(0, 9));
        press(d, $urandom_range(1, 6), $urandom_range(2, 6));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
